// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle control unit: states, ALU ops, opcodes and mux selects.
package mcu_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_OR   = 5'd2;
    localparam logic [4:0] ALU_LUI  = 5'd3;
    localparam logic [4:0] ALU_PASS = 5'd4;
    localparam logic [4:0] ALU_SLL  = 5'd5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;

    localparam logic [1:0] NPC_SEQ = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_JMP = 2'd2;
    localparam logic [1:0] NPC_RS  = 2'd3;

    // One-hot instruction class; exactly one bit is set for any instr.
    typedef struct packed {
        logic alu_r;
        logic alu_i;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic ill;
    } cls_t;

endpackage

// File: rtl/mcu_decode.sv
// Combinational instruction decode: class plus the static EXEC selects.
// sll support is compiled in only when MCU_SLL_EN is defined.
module mcu_decode import mcu_pkg::*; (
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output cls_t       o_cls,
    output logic [4:0] o_aluop,
    output logic       o_alusrc_a,
    output logic       o_alusrc_b,
    output logic       o_ext_op
);

    always_comb begin
        o_cls      = '0;
        o_aluop    = ALU_ADD;
        o_alusrc_a = 1'b0;
        o_alusrc_b = 1'b0;
        o_ext_op   = 1'b0;
        case (i_op)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADDU: o_cls.alu_r = 1'b1;
                    FN_SUBU: begin
                        o_cls.alu_r = 1'b1;
                        o_aluop     = ALU_SUB;
                    end
                    FN_JR:   o_cls.jr = 1'b1;
`ifdef MCU_SLL_EN
                    FN_SLL: begin
                        o_cls.alu_r = 1'b1;
                        o_aluop     = ALU_SLL;
                        o_alusrc_a  = 1'b1;
                    end
`endif
                    default: o_cls.ill = 1'b1;
                endcase
            end
            OP_ORI: begin
                o_cls.alu_i = 1'b1;
                o_aluop     = ALU_OR;
                o_alusrc_b  = 1'b1;
            end
            OP_LUI: begin
                o_cls.alu_i = 1'b1;
                o_aluop     = ALU_LUI;
                o_alusrc_b  = 1'b1;
            end
            OP_LW: begin
                o_cls.lw   = 1'b1;
                o_alusrc_b = 1'b1;
                o_ext_op   = 1'b1;
            end
            OP_SW: begin
                o_cls.sw   = 1'b1;
                o_alusrc_b = 1'b1;
                o_ext_op   = 1'b1;
            end
            OP_BEQ: begin
                o_cls.beq = 1'b1;
                o_aluop   = ALU_SUB;
            end
            OP_J:    o_cls.j   = 1'b1;
            OP_JAL:  o_cls.jal = 1'b1;
            default: o_cls.ill = 1'b1;
        endcase
    end

endmodule

// File: rtl/mcu_ctrl.sv
// Multi-cycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencer and retired-instruction counter.
// Define MCU_SLL_EN to decode sll; otherwise funct 000000 is an unknown instruction.
module mcu_ctrl import mcu_pkg::*; #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             dm_we,
    output logic [4:0]       aluop,
    output logic             alusrc_b,
    output logic             alusrc_a,
    output logic             ext_op,
    output logic [1:0]       regdst,
    output logic [1:0]       wd_sel,
    output logic [1:0]       npc_sel,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;
    cls_t             w_cls;
    logic [4:0]       w_aluop;
    logic             w_alusrc_a;
    logic             w_alusrc_b;
    logic             w_ext_op;
    logic             w_unused_instr;

    // Register fields are consumed by the datapath, not by control.
    assign w_unused_instr = ^instr[25:6];

    mcu_decode u_decode (
        .i_op       (instr[31:26]),
        .i_funct    (instr[5:0]),
        .o_cls      (w_cls),
        .o_aluop    (w_aluop),
        .o_alusrc_a (w_alusrc_a),
        .o_alusrc_b (w_alusrc_b),
        .o_ext_op   (w_ext_op)
    );

    always_comb begin
        w_next   = r_state;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        rf_we    = 1'b0;
        dm_we    = 1'b0;
        aluop    = ALU_ADD;
        alusrc_a = 1'b0;
        alusrc_b = 1'b0;
        ext_op   = 1'b0;
        regdst   = RD_RT;
        wd_sel   = WD_ALU;
        npc_sel  = NPC_SEQ;
        unique case (r_state)
            S_FETCH: begin
                ir_we = mem_ready;
                pc_we = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_cls.j || w_cls.jal) begin
                    pc_we   = 1'b1;
                    npc_sel = NPC_JMP;
                end
                if (w_cls.jal) begin
                    rf_we  = 1'b1;
                    regdst = RD_RA;
                    wd_sel = WD_PC;
                end
                if (w_cls.jr) begin
                    pc_we   = 1'b1;
                    npc_sel = NPC_RS;
                end
                if (w_cls.j || w_cls.jal || w_cls.jr || w_cls.ill) w_next = S_FETCH;
                else                                                w_next = S_EXEC;
            end
            S_EXEC: begin
                aluop    = w_aluop;
                alusrc_a = w_alusrc_a;
                alusrc_b = w_alusrc_b;
                ext_op   = w_ext_op;
                if (w_cls.beq) begin
                    pc_we   = zero;
                    npc_sel = NPC_BR;
                end
                if (w_cls.lw || w_cls.sw)          w_next = S_MEM;
                else if (w_cls.alu_r || w_cls.alu_i) w_next = S_WB;
                else                               w_next = S_FETCH;
            end
            S_MEM: begin
                dm_we = w_cls.sw && mem_ready;
                if (mem_ready) w_next = w_cls.lw ? S_WB : S_FETCH;
            end
            S_WB: begin
                rf_we  = 1'b1;
                regdst = w_cls.alu_r ? RD_RD : RD_RT;
                wd_sel = w_cls.lw ? WD_MEM : WD_ALU;
                w_next = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
        // Reset silences every enable and select, even mid-instruction.
        if (reset) begin
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            rf_we    = 1'b0;
            dm_we    = 1'b0;
            aluop    = ALU_ADD;
            alusrc_a = 1'b0;
            alusrc_b = 1'b0;
            ext_op   = 1'b0;
            regdst   = RD_RT;
            wd_sel   = WD_ALU;
            npc_sel  = NPC_SEQ;
        end
    end

    assign w_last = (r_state != S_FETCH) && (w_next == S_FETCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_last) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign state     = r_state;
    assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_mcu_ctrl.sv
// Directed bench for mcu_ctrl: per-instruction expected cycle schedule checked every cycle,
// plus literal counter and latency checks. A narrow counter exercises wrap-around.
module tb_mcu_ctrl;

    localparam int CW = 4;

`ifdef MCU_SLL_EN
    localparam int SLL_LAT = 4;
`else
    localparam int SLL_LAT = 2;
`endif

    localparam int K_ADDU = 0, K_SUBU = 1, K_SLL = 2, K_ORI = 3, K_LUI = 4, K_LW = 5;
    localparam int K_SW = 6, K_BEQ = 7, K_J = 8, K_JAL = 9, K_JR = 10, K_ILL = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   instr = 32'h0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          ir_we, pc_we, rf_we, dm_we;
    logic [4:0]    aluop;
    logic          alusrc_b, alusrc_a, ext_op;
    logic [1:0]    regdst, wd_sel, npc_sel;
    logic [2:0]    state;
    logic [CW-1:0] instr_cnt;

    mcu_ctrl #(.CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .rf_we     (rf_we),
        .dm_we     (dm_we),
        .aluop     (aluop),
        .alusrc_b  (alusrc_b),
        .alusrc_a  (alusrc_a),
        .ext_op    (ext_op),
        .regdst    (regdst),
        .wd_sel    (wd_sel),
        .npc_sel   (npc_sel),
        .state     (state),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [20:0]   sig;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            nf_cnt = 0;
    int            nf_start = 0;
    logic          snap = 1'b0;
    logic          pend = 1'b0;
    int            pend_cnt, pend_lat, pend_fw;
    logic [CW-1:0] m_cnt = '0;
    logic          mr_x = 1'b0;

    // {state, ir/pc/rf/dm we, aluop, alusrc_a/alusrc_b/ext_op, regdst, wd_sel, npc_sel}
    function automatic logic [20:0] mk(input logic [2:0] st, input logic [3:0] we,
                                       input logic [4:0] op, input logic [2:0] sel,
                                       input logic [1:0] rd, input logic [1:0] wd,
                                       input logic [1:0] npc);
        return {st, we, op, sel, rd, wd, npc};
    endfunction

    function automatic int kind_of(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100001: return K_ADDU;
                    6'b100011: return K_SUBU;
                    6'b001000: return K_JR;
`ifdef MCU_SLL_EN
                    6'b000000: return K_SLL;
`endif
                    default:   return K_ILL;
                endcase
            end
            6'b001101: return K_ORI;
            6'b001111: return K_LUI;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            default:   return K_ILL;
        endcase
    endfunction

    // Compare process: every cycle with a scheduled expectation is checked on the falling edge.
    always @(negedge clk) begin : cmp
        exp_t e;
        if (!reset && state != 3'd0) nf_cnt++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({state, ir_we, pc_we, rf_we, dm_we, aluop, alusrc_a, alusrc_b, ext_op,
                 regdst, wd_sel, npc_sel} !== e.sig) begin
                n_bad++;
                $display("FAIL outputs t=%0t instr=%h got=%h want=%h", $time, instr,
                         {state, ir_we, pc_we, rf_we, dm_we, aluop, alusrc_a, alusrc_b,
                          ext_op, regdst, wd_sel, npc_sel}, e.sig);
            end
            n_cmp++;
            if (instr_cnt !== e.cnt) begin
                n_bad++;
                $display("FAIL instr_cnt t=%0t got=%0d want=%0d", $time, instr_cnt, e.cnt);
            end
        end
    end

    task automatic step(input logic rst, input logic mr, input logic [31:0] ins, input logic z,
                        input logic [20:0] sig, input logic [CW-1:0] cnt);
        int lat_meas;
        @(posedge clk);
        #1;
        if (pend) begin
            pend = 1'b0;
            n_cmp++;
            if (instr_cnt !== pend_cnt[CW-1:0]) begin
                n_bad++;
                $display("FAIL cnt_literal got=%0d want=%0d", instr_cnt, pend_cnt);
            end
            lat_meas = nf_cnt - nf_start + pend_fw + 1;
            n_cmp++;
            if (lat_meas != pend_lat) begin
                n_bad++;
                $display("FAIL latency instr=%h got=%0d want=%0d", instr, lat_meas, pend_lat);
            end
        end
        if (snap) begin
            snap     = 1'b0;
            nf_start = nf_cnt;
        end
        reset     = rst;
        mem_ready = mr;
        instr     = ins;
        zero      = z;
        exp_q.push_back('{sig: sig, cnt: cnt});
    endtask

    // Expected schedule for one instruction, built from the per-instruction state path.
    task automatic run_instr(input logic [31:0] ins, input logic z, input int fw, input int mw,
                             input int lat, input int cnt_lit);
        int         k;
        logic [20:0] s;
        k    = kind_of(ins);
        mr_x = ~mr_x;
        snap = 1'b1;
        for (int i = 0; i < fw; i++) step(1'b0, 1'b0, ins, z, mk(3'd0, 4'b0000, 5'd0, 3'b000, 2'd0, 2'd0, 2'd0), m_cnt);
        step(1'b0, 1'b1, ins, z, mk(3'd0, 4'b1100, 5'd0, 3'b000, 2'd0, 2'd0, 2'd0), m_cnt);
        case (k)
            K_J:     s = mk(3'd1, 4'b0100, 5'd0, 3'b000, 2'd0, 2'd0, 2'd2);
            K_JAL:   s = mk(3'd1, 4'b0110, 5'd0, 3'b000, 2'd2, 2'd2, 2'd2);
            K_JR:    s = mk(3'd1, 4'b0100, 5'd0, 3'b000, 2'd0, 2'd0, 2'd3);
            default: s = mk(3'd1, 4'b0000, 5'd0, 3'b000, 2'd0, 2'd0, 2'd0);
        endcase
        step(1'b0, mr_x, ins, z, s, m_cnt);
        if (!(k inside {K_J, K_JAL, K_JR, K_ILL})) begin
            case (k)
                K_ADDU:  s = mk(3'd2, 4'b0000, 5'd0, 3'b000, 2'd0, 2'd0, 2'd0);
                K_SUBU:  s = mk(3'd2, 4'b0000, 5'd1, 3'b000, 2'd0, 2'd0, 2'd0);
                K_SLL:   s = mk(3'd2, 4'b0000, 5'd5, 3'b100, 2'd0, 2'd0, 2'd0);
                K_ORI:   s = mk(3'd2, 4'b0000, 5'd2, 3'b010, 2'd0, 2'd0, 2'd0);
                K_LUI:   s = mk(3'd2, 4'b0000, 5'd3, 3'b010, 2'd0, 2'd0, 2'd0);
                K_BEQ:   s = mk(3'd2, {1'b0, z, 2'b00}, 5'd1, 3'b000, 2'd0, 2'd0, 2'd1);
                default: s = mk(3'd2, 4'b0000, 5'd0, 3'b011, 2'd0, 2'd0, 2'd0);
            endcase
            step(1'b0, mr_x, ins, z, s, m_cnt);
            if (k == K_LW || k == K_SW) begin
                for (int i = 0; i < mw; i++) step(1'b0, 1'b0, ins, z, mk(3'd3, 4'b0000, 5'd0, 3'b000, 2'd0, 2'd0, 2'd0), m_cnt);
                step(1'b0, 1'b1, ins, z, mk(3'd3, {3'b000, k == K_SW}, 5'd0, 3'b000, 2'd0, 2'd0, 2'd0), m_cnt);
            end
            if (k != K_BEQ && k != K_SW) begin
                if (k == K_LW)                   s = mk(3'd4, 4'b0010, 5'd0, 3'b000, 2'd0, 2'd1, 2'd0);
                else if (k == K_ORI || k == K_LUI) s = mk(3'd4, 4'b0010, 5'd0, 3'b000, 2'd0, 2'd0, 2'd0);
                else                             s = mk(3'd4, 4'b0010, 5'd0, 3'b000, 2'd1, 2'd0, 2'd0);
                step(1'b0, mr_x, ins, z, s, m_cnt);
            end
        end
        m_cnt    = m_cnt + 1'b1;
        pend     = 1'b1;
        pend_cnt = cnt_lit;
        pend_lat = lat;
        pend_fw  = fw;
    endtask

    localparam logic [20:0] IDLE = 21'h0;

    initial begin
        step(1'b1, 1'b1, 32'h0, 1'b0, IDLE, '0);
        step(1'b1, 1'b1, 32'h0, 1'b0, IDLE, '0);

        //        instr         z  fw mw lat       cnt
        run_instr(32'h00221821, 0, 0, 0, 4,        1);  // addu $3,$1,$2
        run_instr(32'h00221823, 0, 1, 0, 5,        2);  // subu, one FETCH wait
        run_instr(32'h34221234, 0, 0, 0, 4,        3);  // ori
        run_instr(32'h3C05ABCD, 0, 0, 0, 4,        4);  // lui
        run_instr(32'h8C240008, 0, 0, 2, 7,        5);  // lw, two MEM waits
        run_instr(32'hAC240004, 0, 0, 1, 5,        6);  // sw, one MEM wait
        run_instr(32'h10220003, 1, 0, 0, 3,        7);  // beq taken
        run_instr(32'h10220003, 0, 0, 0, 3,        8);  // beq not taken
        run_instr(32'h08000010, 0, 0, 0, 2,        9);  // j
        run_instr(32'h0C000010, 0, 0, 0, 2,        10); // jal
        run_instr(32'h03E00008, 0, 0, 0, 2,        11); // jr $31
        run_instr(32'hFC000000, 0, 0, 0, 2,        12); // illegal opcode
        run_instr(32'h00011100, 0, 0, 0, SLL_LAT,  13); // sll $2,$1,4
        run_instr(32'h00221820, 0, 0, 0, 2,        14); // unknown funct
        run_instr(32'h8C240008, 0, 2, 0, 7,        15); // lw, two FETCH waits
        run_instr(32'h00221821, 1, 0, 0, 4,        0);  // addu, counter wraps
        run_instr(32'hAC240004, 0, 0, 0, 4,        1);  // sw

        // Reset lands while sw sits in MEM with mem_ready high: no store, then clean restart.
        step(1'b0, 1'b1, 32'hAC240004, 1'b0, mk(3'd0, 4'b1100, 5'd0, 3'b000, 2'd0, 2'd0, 2'd0), m_cnt);
        pend = 1'b0;
        step(1'b0, 1'b1, 32'hAC240004, 1'b0, mk(3'd1, 4'b0000, 5'd0, 3'b000, 2'd0, 2'd0, 2'd0), m_cnt);
        step(1'b0, 1'b1, 32'hAC240004, 1'b0, mk(3'd2, 4'b0000, 5'd0, 3'b011, 2'd0, 2'd0, 2'd0), m_cnt);
        step(1'b1, 1'b1, 32'hAC240004, 1'b0, mk(3'd3, 4'b0000, 5'd0, 3'b000, 2'd0, 2'd0, 2'd0), m_cnt);
        m_cnt = '0;
        step(1'b0, 1'b0, 32'hAC240004, 1'b0, IDLE, m_cnt);
        run_instr(32'h00221821, 0, 0, 0, 4, 1);

        step(1'b0, 1'b0, 32'h0, 1'b0, IDLE, m_cnt);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mcu_ctrl.md
# mcu_ctrl

Multi-cycle control unit: the producer side of the ALU control interface. Each cycle it sequences the datapath through FETCH, DECODE, EXEC, MEM and WB states and drives `aluop`, operand selects and all register-file, PC, IR and data-memory write enables. It consumes the ALU `zero` flag and a memory-ready handshake. It sits between the instruction register and the datapath muxes of the multi-cycle CPU.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `instr` in 32: current IR contents; held stable by the IR outside FETCH.
- `zero` in 1: ALU equality flag, meaning `a == b`.
- `mem_ready` in 1: the memory access issued this cycle completes this cycle.
- `ir_we`, `pc_we`, `rf_we`, `dm_we` out 1 each: write enables for IR, PC, register file and data memory.
- `aluop` out 5: 0 add, 1 sub, 2 or, 3 lui (`b[15:0]<<16`), 4 pass a, 5 sll (`b<<a[4:0]`).
- `alusrc_b` out 1: ALU operand B select. 0 = rt, 1 = extended immediate.
- `alusrc_a` out 1: ALU operand A select. 0 = rs, 1 = shamt.
- `ext_op` out 1: immediate extension. 0 = zero-extend, 1 = sign-extend.
- `regdst` out 2: destination register. 0 = rt, 1 = rd, 2 = $31.
- `wd_sel` out 2: register write data. 0 = ALU, 1 = memory, 2 = PC (already PC+4).
- `npc_sel` out 2: next PC. 0 = PC+4, 1 = branch (PC + sext(imm)<<2), 2 = {PC[31:28], imm26, 2'b00}, 3 = rs.
- `state` out 3: current state, for debug.
- `instr_cnt` out CNT_W: count of retired instructions.

## Operation
- Supported instructions:
  - R-type (op 000000): addu (funct 100001), subu (100011), sll (000000), jr (001000).
  - I-type: ori 001101, lui 001111, lw 100011, sw 101011, beq 000100.
  - J-type: j 000010, jal 000011.
- State path per instruction:
  - ALU ops: F→D→E→W.
  - lw: F→D→E→M→W.
  - sw: F→D→E→M.
  - beq: F→D→E.
  - j, jal, jr: F→D.
  - Unknown opcode or funct: F→D, then back to F with no writes. The instruction still counts as retired.
- FETCH:
  - `ir_we = pc_we = mem_ready`, `npc_sel = 0`.
  - Stays in FETCH while `mem_ready = 0`.
- DECODE:
  - j: `pc_we = 1`, `npc_sel = 2`.
  - jr: `pc_we = 1`, `npc_sel = 3`.
  - jal: `pc_we = 1`, `npc_sel = 2`, plus `rf_we = 1`, `regdst = 2`, `wd_sel = 2` in the same cycle.
- EXEC `aluop` and selects:
  - addu: 0. subu: 1.
  - ori: 2, with `ext_op = 0`, `alusrc_b = 1`.
  - lui: 3, with `alusrc_b = 1`.
  - sll: 5, with `alusrc_a = 1`.
  - lw/sw: 0, with `ext_op = 1`, `alusrc_b = 1`.
  - beq: 1, with `pc_we = zero` and `npc_sel = 1`.
- MEM:
  - sw: `dm_we = mem_ready`.
  - Stays in MEM while `mem_ready = 0`. `dm_we` is never high without `mem_ready`.
- WB:
  - `rf_we = 1`.
  - R-type: `regdst = 1`, `wd_sel = 0`.
  - ori/lui: `regdst = 0`, `wd_sel = 0`.
  - lw: `regdst = 0`, `wd_sel = 1`.
- `instr_cnt` increments by 1 on the final cycle of each instruction, i.e. the cycle whose next state is FETCH. It wraps modulo 2^CNT_W.
- Outputs not listed for a state are 0. `aluop` defaults to 0.

## Timing
- Enables are combinational from the state register, `instr`, `zero` and `mem_ready`. The state register and `instr_cnt` are registered.
- Reset, while `reset = 1`:
  - state = FETCH, `instr_cnt = 0`.
  - All write enables are forced to 0 regardless of `mem_ready`.
  - All selects and `aluop` are 0.
- Reset asserted mid-instruction aborts it on the next edge. No partial write occurs after that edge.
- Latency with `mem_ready` held at 1: ALU ops 4 cycles, lw 5, sw 4, beq 3, j/jal/jr 2.
- Each low cycle of `mem_ready` in FETCH or MEM adds one cycle.
- beq with `zero = 0` takes the same 3 cycles, with `pc_we = 0` in EXEC.

## Configuration
- `MCU_SLL_EN` defined: sll decodes as described above.
- `MCU_SLL_EN` undefined: funct 000000 is treated as an unknown instruction (F→D, no writes, counted). `alusrc_a` is tied to 0 and `aluop` 5 is never issued.

## Structure
- Shared package `mcu_pkg` holds:
  - the 3-bit state encoding S_FETCH=0, S_DECODE=1, S_EXEC=2, S_MEM=3, S_WB=4;
  - the `aluop` constants ALU_ADD..ALU_SLL;
  - the opcode and funct constants;
  - the `regdst`, `wd_sel` and `npc_sel` encodings.
- One sub-module, `mcu_decode`: purely combinational. It maps `instr` to a one-hot instruction class and the static selects. `mcu_ctrl` holds the FSM, the per-state enable gating and the counter.

## Test plan
- addu $3,$1,$2 (0x00221821), `mem_ready = 1`:
  - -> states 0,1,2,4,0.
  - `aluop = 0` in EXEC.
  - `rf_we = 1`, `regdst = 1` in WB.
  - `instr_cnt` 0→1.
- lw with `mem_ready` low for 2 cycles in MEM:
  - -> 7-cycle instruction, `rf_we` only in the single WB cycle, `wd_sel = 1`.
- beq (0x10220003) with `zero = 1`:
  - -> `pc_we = 1`, `npc_sel = 1` in EXEC.
- beq with `zero = 0`:
  - -> `pc_we = 0`.
  - Both cases return to FETCH after 3 cycles.
- jal 0x0C000010:
  - -> DECODE has `pc_we = rf_we = 1`, `npc_sel = 2`, `regdst = 2`, `wd_sel = 2`.
  - 2 cycles total.
- Illegal opcode 0xFC000000:
  - -> F→D→F with no enables high, `instr_cnt` +1.
  - Separately: `reset` asserted during sw in MEM -> `dm_we = 0` that cycle, then state = 0 and `instr_cnt = 0`.
